// File: rtl/fft_cfg_pkg.sv
// Shared definitions for the FFT configuration receiver: word layout, legality limits
// and the FSM state type.
package fft_cfg_pkg;

  localparam int unsigned CFG_W     = 24;
  localparam int unsigned NFFT_LSB  = 0;
  localparam int unsigned NFFT_W    = 5;
  localparam int unsigned CP_LSB    = 8;
  localparam int unsigned CP_W      = 7;
  localparam int unsigned FWD_BIT   = 16;

  // Bits [7:5], [15] and [23:17] must be zero in a legal word.
  localparam logic [CFG_W-1:0] RSVD_MASK = 24'hFE_80_E0;

  localparam int unsigned NFFT_MIN_DEF = 3;
  localparam int unsigned NFFT_MAX_DEF = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StPending,
    StApply
  } state_t;

endpackage

// File: rtl/fft_config_receiver_if.sv
// Configuration channel plus the observe-only data-stream monitor taps.
interface fft_config_receiver_if;
  import fft_cfg_pkg::*;

  logic             s_cfg_tvalid;
  logic [CFG_W-1:0] s_cfg_tdata;
  logic             s_cfg_tready;
  logic             mon_tvalid;
  logic             mon_tready;
  logic             mon_tlast;

  modport master (
    output s_cfg_tvalid,
    output s_cfg_tdata,
    input  s_cfg_tready,
    output mon_tvalid,
    output mon_tready,
    output mon_tlast
  );

  modport slave (
    input  s_cfg_tvalid,
    input  s_cfg_tdata,
    output s_cfg_tready,
    input  mon_tvalid,
    input  mon_tready,
    input  mon_tlast
  );

endinterface

// File: rtl/fft_cfg_check.sv
// Combinational legality check of a 24-bit FFT configuration word.
module fft_cfg_check
  import fft_cfg_pkg::*;
#(
  parameter int unsigned NFFT_MIN = NFFT_MIN_DEF,
  parameter int unsigned NFFT_MAX = NFFT_MAX_DEF
) (
  input  logic [CFG_W-1:0] word,
  output logic             legal
);

  logic [NFFT_W-1:0] nfft;
  logic [CP_W-1:0]   cp_len;
  logic              nfft_ok;
  logic              rsvd_ok;
  logic              cp_ok;

  assign nfft   = word[NFFT_LSB +: NFFT_W];
  assign cp_len = word[CP_LSB +: CP_W];

  assign nfft_ok = ({27'd0, nfft} >= NFFT_MIN) && ({27'd0, nfft} <= NFFT_MAX);
  assign rsvd_ok = (word & RSVD_MASK) == '0;
  // cp_len < 2^nfft  <=>  no cp_len bits survive a right shift by nfft
  assign cp_ok   = (({25'd0, cp_len} >> nfft) == 32'd0);

  assign legal = nfft_ok && rsvd_ok && cp_ok;

endmodule

// File: rtl/fft_config_receiver.sv
// Accepts FFT configuration words, validates them and applies legal ones, deferring
// the update to the end of an in-flight data frame.
module fft_config_receiver
  import fft_cfg_pkg::*;
#(
  parameter int unsigned NFFT_MIN = NFFT_MIN_DEF,
  parameter int unsigned NFFT_MAX = NFFT_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_config_receiver_if.slave  bus,
  output logic [NFFT_W-1:0]     nfft,
  output logic [CP_W-1:0]       cp_len,
  output logic                  fwd_inv,
  output logic                  cfg_valid,
  output logic                  cfg_pending,
  output logic                  cfg_applied,
  output logic                  cfg_error,
  output logic [7:0]            apply_cnt,
  output logic [7:0]            error_cnt
);

  state_t            state_q, state_d;
  logic [CFG_W-1:0]  hold_q;
  logic              in_frame_q, in_frame_d;
  logic [NFFT_W-1:0] nfft_q;
  logic [CP_W-1:0]   cp_len_q;
  logic              fwd_inv_q;
  logic              valid_q;
  logic              applied_q;
  logic              error_q;
  logic [7:0]        apply_cnt_q;
  logic [7:0]        error_cnt_q;
  logic              legal;
  logic              accept;
  logic              beat;
  logic              beat_last;
  logic              do_apply;
  logic              do_error;

  fft_cfg_check #(
    .NFFT_MIN (NFFT_MIN),
    .NFFT_MAX (NFFT_MAX)
  ) u_check (
    .word  (hold_q),
    .legal (legal)
  );

  assign bus.s_cfg_tready = rst && (state_q == StIdle);
  assign accept    = bus.s_cfg_tvalid && bus.s_cfg_tready;
  assign beat      = bus.mon_tvalid && bus.mon_tready;
  assign beat_last = beat && bus.mon_tlast;

  always_comb begin
    in_frame_d = in_frame_q;
    if (beat) begin
      in_frame_d = !bus.mon_tlast;
    end
  end

  always_comb begin
    state_d  = state_q;
    do_apply = 1'b0;
    do_error = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!legal) begin
          state_d  = StIdle;
          do_error = 1'b1;
        end else if (in_frame_q && !beat_last) begin
          state_d = StPending;
        end else begin
          // A frame ending during the check cycle needs no deferral.
          state_d = StApply;
        end
      end
      StPending: begin
        if (beat_last) begin
          state_d = StApply;
        end
      end
      StApply: begin
        do_apply = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      in_frame_q  <= 1'b0;
      nfft_q      <= '0;
      cp_len_q    <= '0;
      fwd_inv_q   <= 1'b0;
      valid_q     <= 1'b0;
      applied_q   <= 1'b0;
      error_q     <= 1'b0;
      apply_cnt_q <= '0;
      error_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_frame_q <= in_frame_d;
      applied_q  <= do_apply;
      error_q    <= do_error;
      if (accept) begin
        hold_q <= bus.s_cfg_tdata;
      end
      if (do_apply) begin
        nfft_q      <= hold_q[NFFT_LSB +: NFFT_W];
        cp_len_q    <= hold_q[CP_LSB +: CP_W];
        fwd_inv_q   <= hold_q[FWD_BIT];
        valid_q     <= 1'b1;
        apply_cnt_q <= apply_cnt_q + 8'd1;
      end
      if (do_error) begin
        error_cnt_q <= error_cnt_q + 8'd1;
      end
    end
  end

  assign nfft        = nfft_q;
  assign cp_len      = cp_len_q;
  assign fwd_inv     = fwd_inv_q;
  assign cfg_valid   = valid_q;
  assign cfg_pending = rst && (state_q == StPending);
  assign cfg_applied = applied_q;
  assign cfg_error   = error_q;
  assign apply_cnt   = apply_cnt_q;
  assign error_cnt   = error_cnt_q;

endmodule

// File: tb/tb_fft_config_receiver.sv
// Directed and randomized checks of fft_config_receiver against a word-level reference model.
module tb_fft_config_receiver;

  logic       clk;
  logic       rst;
  logic [4:0] nfft;
  logic [6:0] cp_len;
  logic       fwd_inv;
  logic       cfg_valid;
  logic       cfg_pending;
  logic       cfg_applied;
  logic       cfg_error;
  logic [7:0] apply_cnt;
  logic [7:0] error_cnt;

  int n_checks;
  int n_fail;

  // Reference model state
  int exp_nfft;
  int exp_cp;
  int exp_fwd;
  int exp_valid;
  int exp_acnt;
  int exp_ecnt;

  fft_config_receiver_if bus ();

  fft_config_receiver #(
    .NFFT_MIN (3),
    .NFFT_MAX (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .nfft        (nfft),
    .cp_len      (cp_len),
    .fwd_inv     (fwd_inv),
    .cfg_valid   (cfg_valid),
    .cfg_pending (cfg_pending),
    .cfg_applied (cfg_applied),
    .cfg_error   (cfg_error),
    .apply_cnt   (apply_cnt),
    .error_cnt   (error_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit is_legal(input logic [23:0] w);
    int n;
    int cp;
    n  = int'(w[4:0]);
    cp = int'(w[14:8]);
    if (n < 3 || n > 16) return 1'b0;
    if (w[7:5] != 3'd0 || w[15] != 1'b0 || w[23:17] != 7'd0) return 1'b0;
    return cp < (1 << n);
  endfunction

  function automatic logic [23:0] rand_legal();
    int n;
    int cpmax;
    logic [23:0] w;
    n     = $urandom_range(16, 3);
    cpmax = (n >= 7) ? 127 : (1 << n) - 1;
    w     = '0;
    w[4:0]  = 5'(n);
    w[14:8] = 7'($urandom_range(cpmax, 0));
    w[16]   = 1'($urandom_range(1, 0));
    return w;
  endfunction

  task automatic model_apply(input logic [23:0] w);
    exp_nfft  = int'(w[4:0]);
    exp_cp    = int'(w[14:8]);
    exp_fwd   = int'(w[16]);
    exp_valid = 1;
    exp_acnt  = (exp_acnt + 1) % 256;
  endtask

  task automatic model_reset();
    exp_nfft  = 0;
    exp_cp    = 0;
    exp_fwd   = 0;
    exp_valid = 0;
    exp_acnt  = 0;
    exp_ecnt  = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_nfft"},  32'(nfft),      32'(exp_nfft));
    check({tag, "_cp"},    32'(cp_len),    32'(exp_cp));
    check({tag, "_fwd"},   32'(fwd_inv),   32'(exp_fwd));
    check({tag, "_valid"}, 32'(cfg_valid), 32'(exp_valid));
    check({tag, "_acnt"},  32'(apply_cnt), 32'(exp_acnt));
    check({tag, "_ecnt"},  32'(error_cnt), 32'(exp_ecnt));
  endtask

  // Leaves the bench at a negedge with s_cfg_tready high (or a failed check).
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.s_cfg_tready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(bus.s_cfg_tready), 32'd1);
  endtask

  // Sends one word with no frame active and checks the result timing.
  task automatic txn(input string tag, input logic [23:0] w);
    bit legal;
    legal = is_legal(w);
    wait_ready();
    bus.s_cfg_tvalid = 1'b1;
    bus.s_cfg_tdata  = w;
    @(negedge clk);
    bus.s_cfg_tvalid = 1'b0;
    bus.s_cfg_tdata  = 24'($urandom());
    check({tag, "_busy"}, 32'(bus.s_cfg_tready), 32'd0);
    @(negedge clk);
    if (!legal) begin
      exp_ecnt = (exp_ecnt + 1) % 256;
      check({tag, "_err"}, 32'(cfg_error), 32'd1);
      check({tag, "_noapp"}, 32'(cfg_applied), 32'd0);
    end else begin
      check({tag, "_noerr"}, 32'(cfg_error), 32'd0);
      check({tag, "_early"}, 32'(cfg_applied), 32'd0);
      @(negedge clk);
      model_apply(w);
      check({tag, "_app"}, 32'(cfg_applied), 32'd1);
    end
    check_outputs(tag);
  endtask

  task automatic mon_beat(input logic last);
    @(negedge clk);
    bus.mon_tvalid = 1'b1;
    bus.mon_tready = 1'b1;
    bus.mon_tlast  = last;
    @(negedge clk);
    bus.mon_tvalid = 1'b0;
    bus.mon_tready = 1'b0;
    bus.mon_tlast  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst = 1'b0;
    bus.s_cfg_tvalid = 1'b0;
    bus.s_cfg_tdata  = '0;
    bus.mon_tvalid   = 1'b0;
    bus.mon_tready   = 1'b0;
    bus.mon_tlast    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tready", 32'(bus.s_cfg_tready), 32'd0);
    check("rst_pending", 32'(cfg_pending), 32'd0);
    check("rst_applied", 32'(cfg_applied), 32'd0);
    check("rst_error", 32'(cfg_error), 32'd0);
    check_outputs("rst");
    rst = 1'b1;
    #1;
    check("rst_release_tready", 32'(bus.s_cfg_tready), 32'd1);

    // Idle legal word
    txn("idle_legal", 24'h01_0A_06);
    @(negedge clk);
    check("idle_legal_pulse_end", 32'(cfg_applied), 32'd0);

    // Mid-frame deferral
    mon_beat(1'b0);
    wait_ready();
    bus.s_cfg_tvalid = 1'b1;
    bus.s_cfg_tdata  = 24'h00_05_04;
    @(negedge clk);
    bus.s_cfg_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("defer_pending", 32'(cfg_pending), 32'd1);
      check("defer_tready", 32'(bus.s_cfg_tready), 32'd0);
      check("defer_hold_nfft", 32'(nfft), 32'(exp_nfft));
      check("defer_hold_cp", 32'(cp_len), 32'(exp_cp));
    end
    bus.mon_tvalid = 1'b1;
    bus.mon_tready = 1'b1;
    bus.mon_tlast  = 1'b1;
    @(negedge clk);
    bus.mon_tvalid = 1'b0;
    bus.mon_tready = 1'b0;
    bus.mon_tlast  = 1'b0;
    check("defer_left_pending", 32'(cfg_pending), 32'd0);
    check("defer_still_old", 32'(nfft), 32'(exp_nfft));
    @(negedge clk);
    model_apply(24'h00_05_04);
    check("defer_app", 32'(cfg_applied), 32'd1);
    check_outputs("defer");

    // Illegal words
    txn("bad_nfft", 24'h00_00_02);
    txn("bad_rsvd", 24'h00_00_84);
    txn("bad_cp", 24'h00_10_04);
    check("bad_ecnt3", 32'(error_cnt), 32'd3);

    // Acceptance coinciding with the closing tlast beat
    mon_beat(1'b0);
    wait_ready();
    bus.s_cfg_tvalid = 1'b1;
    bus.s_cfg_tdata  = 24'h00_1F_05;
    bus.mon_tvalid   = 1'b1;
    bus.mon_tready   = 1'b1;
    bus.mon_tlast    = 1'b1;
    @(negedge clk);
    bus.s_cfg_tvalid = 1'b0;
    bus.mon_tvalid   = 1'b0;
    bus.mon_tready   = 1'b0;
    bus.mon_tlast    = 1'b0;
    @(negedge clk);
    check("simul_no_pending", 32'(cfg_pending), 32'd0);
    @(negedge clk);
    model_apply(24'h00_1F_05);
    check("simul_app", 32'(cfg_applied), 32'd1);
    check_outputs("simul");

    // Randomized mix of legal and arbitrary words
    for (int i = 0; i < 40; i++) begin
      logic [23:0] w;
      if ($urandom_range(1, 0) == 1) w = rand_legal();
      else w = 24'($urandom());
      txn("rand", w);
    end

    // Reset while a word is pending
    mon_beat(1'b0);
    wait_ready();
    bus.s_cfg_tvalid = 1'b1;
    bus.s_cfg_tdata  = rand_legal();
    @(negedge clk);
    bus.s_cfg_tvalid = 1'b0;
    @(negedge clk);
    check("prst_pending", 32'(cfg_pending), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    check("prst_noapp", 32'(cfg_applied), 32'd0);
    check("prst_tready", 32'(bus.s_cfg_tready), 32'd0);
    check("prst_pend_clr", 32'(cfg_pending), 32'd0);
    check_outputs("prst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("prst_release_tready", 32'(bus.s_cfg_tready), 32'd1);
    @(negedge clk);
    check("prst_noapp_after", 32'(cfg_applied), 32'd0);

    // Counter wrap after 256 applications
    for (int i = 0; i < 256; i++) begin
      txn("wrap", rand_legal());
    end
    check("wrap_acnt", 32'(apply_cnt), 32'd0);
    check("wrap_valid", 32'(cfg_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
